// File: rtl/jtag_pkg.sv
// Shared types and field offsets for the JTAG address/data debug-access block.
package jtag_pkg;

    typedef enum logic {StIdle = 1'b0, StReq = 1'b1} state_e;

    // Status bits at the bottom of the data DR; the data field starts at STAT_W.
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_ERR  = 1;
    localparam int unsigned STAT_W    = 2;

    // Flag offsets above the AW-bit address field in the address DR.
    localparam int unsigned ADDR_WR_OFS  = 0;
    localparam int unsigned ADDR_INC_OFS = 1;

endpackage

// File: rtl/jtag_addr_data_if.sv
// Single-beat req/ack bus between the JTAG access block and the debug bus bridge.
interface jtag_addr_data_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/jtag_shift_reg.sv
// One JTAG data register: qualifies TAP strobes with its select and holds the shift chain.
module jtag_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_sel,
    input  logic         i_capture,
    input  logic         i_shift,
    input  logic         i_update,
    input  logic         i_tdi,
    input  logic [W-1:0] i_cap_data,
    output logic [W-1:0] o_sr,
    output logic         o_update,
    output logic         o_tdo
);
    logic [W-1:0] r_sr;
    logic         w_capture;
    logic         w_shift;

    // Priority CAPTURE > UPDATE > SHIFT.
    assign w_capture = i_sel & i_capture;
    assign o_update  = i_sel & i_update & ~i_capture;
    assign w_shift   = i_sel & i_shift & ~i_update & ~i_capture;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (w_capture) begin
            r_sr <= i_cap_data;
        end else if (w_shift) begin
            r_sr <= {i_tdi, r_sr[W-1:1]};
        end
    end

    assign o_sr  = r_sr;
    assign o_tdo = r_sr[0];
endmodule

// File: rtl/jtag_addr_data.sv
// JTAG debug access: address/command DR and data/status DR launching single-beat bus accesses.
module jtag_addr_data
    import jtag_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 64,
    parameter int unsigned STRIDE = 8
) (
    input  logic             i_tck,
    input  logic             i_reset_n,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic             i_update,
    input  logic             i_tdi,
    input  logic             i_sel_addr,
    input  logic             i_sel_data,
    output logic             o_tdo,
    jtag_addr_data_if.master bus
);
    localparam int unsigned AddrW  = AW + 2;
    localparam int unsigned DataW  = DW + 2;
    localparam int unsigned WrBit  = AW + ADDR_WR_OFS;
    localparam int unsigned IncBit = AW + ADDR_INC_OFS;

    state_e        r_state;
    logic [AW-1:0] r_addr;
    logic          r_inc;
    logic          r_wr;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata;

    logic             w_sel_data;
    logic             w_busy;
    logic [AddrW-1:0] w_addr_cap;
    logic [DataW-1:0] w_data_cap;
    logic [AddrW-1:0] w_addr_sr;
    logic [DataW-1:0] w_data_sr;
    logic             w_addr_upd;
    logic             w_data_upd;
    logic             w_addr_tdo;
    logic             w_data_tdo;

    // Address DR wins when both are selected; the data DR sees no strobes then.
    assign w_sel_data = i_sel_data & ~i_sel_addr;
    assign w_busy     = (r_state == StReq);

    always_comb begin
        w_addr_cap                   = '0;
        w_addr_cap[AW-1:0]           = r_addr;
        w_addr_cap[WrBit]            = r_wr;
        w_addr_cap[IncBit]           = r_inc;
        w_data_cap                   = '0;
        w_data_cap[DataW-1:STAT_W]   = r_rdata;
        w_data_cap[STAT_ERR]         = r_err;
        w_data_cap[STAT_BUSY]        = w_busy;
    end

    jtag_shift_reg #(.W(AddrW)) u_addr_dr (
        .i_clk      (i_tck),
        .i_rst_n    (i_reset_n),
        .i_sel      (i_sel_addr),
        .i_capture  (i_capture),
        .i_shift    (i_shift),
        .i_update   (i_update),
        .i_tdi      (i_tdi),
        .i_cap_data (w_addr_cap),
        .o_sr       (w_addr_sr),
        .o_update   (w_addr_upd),
        .o_tdo      (w_addr_tdo)
    );

    jtag_shift_reg #(.W(DataW)) u_data_dr (
        .i_clk      (i_tck),
        .i_rst_n    (i_reset_n),
        .i_sel      (w_sel_data),
        .i_capture  (i_capture),
        .i_shift    (i_shift),
        .i_update   (i_update),
        .i_tdi      (i_tdi),
        .i_cap_data (w_data_cap),
        .o_sr       (w_data_sr),
        .o_update   (w_data_upd),
        .o_tdo      (w_data_tdo)
    );

    always_ff @(posedge i_tck or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_inc       <= 1'b0;
            r_wr        <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_addr_upd) begin
                        r_addr <= w_addr_sr[AW-1:0];
                        r_wr   <= w_addr_sr[WrBit];
                        r_inc  <= w_addr_sr[IncBit];
                        r_err  <= 1'b0;
                        if (!w_addr_sr[WrBit]) begin
                            r_state    <= StReq;
                            r_bus_req  <= 1'b1;
                            r_bus_we   <= 1'b0;
                            r_bus_addr <= w_addr_sr[AW-1:0];
                        end
                    end else if (w_data_upd) begin
                        r_state    <= StReq;
                        r_bus_req  <= 1'b1;
                        r_bus_we   <= r_wr;
                        r_bus_addr <= r_addr;
                        if (r_wr) begin
                            r_bus_wdata <= w_data_sr[DataW-1:STAT_W];
                        end
                    end
                end
                StReq: begin
                    // Any UPDATE while an access is outstanding is an overrun.
                    r_err <= r_err | w_addr_upd | w_data_upd | (bus.ack & bus.err);
                    if (bus.ack) begin
                        r_state   <= StIdle;
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_rdata <= bus.rdata;
                        end
                        if (r_inc) begin
                            r_addr <= r_addr + AW'(STRIDE);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req   = r_bus_req;
    assign bus.we    = r_bus_we;
    assign bus.addr  = r_bus_addr;
    assign bus.wdata = r_bus_wdata;

    assign o_tdo = i_sel_addr ? w_addr_tdo : (i_sel_data ? w_data_tdo : 1'b0);
endmodule
